// File: rtl/fmul_rsh_round_pipe.sv
// fmul_rsh_round_pipe: two-stage right-shift and round stage for subnormal fmul results.
// Extracts L/G/S and the one-bit-lower L/G/S used for after-rounding tininess. It
// applies the rounding mode and produces the rounded fraction, the carry into the
// minimum normal, inexact and underflow.
// Optional feature macro: FMUL_RSH_ROUND_SKID_EN adds a 1-entry input skid buffer.
// With the skid buffer, in_ready_o comes straight from a flop.
//
// Handshake: a beat transfers on any rising clk edge where valid and ready are both 1.
// A producer holds valid and its data stable until that transfer. Output data stays
// stable while out_valid_o=1 and out_ready_i=0.
module fmul_rsh_round_pipe #(
  parameter int MANT_W = 10,
  parameter int SIG_W  = 2 * (MANT_W + 1),
  parameter int RSH_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SIG_W-1:0]  sig_mul_i,
  input  logic [RSH_W-1:0]  rsh_num_i,
  input  logic [2:0]        rm_i,
  input  logic              sign_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MANT_W-1:0] frac_o,
  output logic              carry_o,
  output logic              inexact_o,
  output logic              uf_o
);

  // Rounding increment for one L/G/S triple; rm values 5-7 fall back to RNE.
  function automatic logic inc_fn(input logic [2:0] rm, input logic sign,
                                  input logic l, input logic g, input logic s);
    case (rm)
      3'd1:    inc_fn = 1'b0;
      3'd2:    inc_fn = sign & (g | s);
      3'd3:    inc_fn = ~sign & (g | s);
      3'd4:    inc_fn = g;
      default: inc_fn = g & (l | s);
    endcase
  endfunction

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv = ~s2_valid | out_ready_i;
  assign s1_adv = ~s1_valid | s2_adv;

  // Beat source feeding S1: either the input port or the skid entry.
  logic              src_valid;
  logic [SIG_W-1:0]  src_sig;
  logic [RSH_W-1:0]  src_rsh;
  logic [2:0]        src_rm;
  logic              src_sign;

`ifdef FMUL_RSH_ROUND_SKID_EN
  logic              skid_valid;
  logic [SIG_W-1:0]  skid_sig;
  logic [RSH_W-1:0]  skid_rsh;
  logic [2:0]        skid_rm;
  logic              skid_sign;

  assign in_ready_o = ~skid_valid;
  assign src_valid  = skid_valid | in_valid_i;
  assign src_sig    = skid_valid ? skid_sig  : sig_mul_i;
  assign src_rsh    = skid_valid ? skid_rsh  : rsh_num_i;
  assign src_rm     = skid_valid ? skid_rm   : rm_i;
  assign src_sign   = skid_valid ? skid_sign : sign_i;

  // Skid entry: catches a beat accepted while S1 is blocked and drains it first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_sig   <= '0;
      skid_rsh   <= '0;
      skid_rm    <= '0;
      skid_sign  <= 1'b0;
    end else if (skid_valid) begin
      if (s1_adv) skid_valid <= 1'b0;
    end else if (in_valid_i && !s1_adv) begin
      skid_valid <= 1'b1;
      skid_sig   <= sig_mul_i;
      skid_rsh   <= rsh_num_i;
      skid_rm    <= rm_i;
      skid_sign  <= sign_i;
    end
  end
`else
  assign in_ready_o = s1_adv;
  assign src_valid  = in_valid_i;
  assign src_sig    = sig_mul_i;
  assign src_rsh    = rsh_num_i;
  assign src_rm     = rm_i;
  assign src_sign   = sign_i;
`endif

  // S1 combinational: bit extraction at p = MANT_W + rsh. The shift zero-fills, so
  // indices past the product width read as 0.
  logic [SIG_W-1:0]  sh;
  logic              c_l, c_g, c_s, c_g_uf, c_s_uf, c_ones;
  logic [MANT_W-1:0] c_frac;

  always_comb begin
    sh     = src_sig >> src_rsh;
    c_l    = sh[MANT_W];
    c_g    = sh[MANT_W-1];
    c_g_uf = sh[MANT_W-2];
    c_frac = sh[MANT_W +: MANT_W];
    c_s    = 1'b0;
    c_s_uf = 1'b0;
    for (int i = 0; i < SIG_W; i++) begin
      if (i < MANT_W - 1 + int'(src_rsh)) c_s    = c_s    | src_sig[i];
      if (i < MANT_W - 2 + int'(src_rsh)) c_s_uf = c_s_uf | src_sig[i];
    end
    c_ones = (src_rsh == RSH_W'(1)) && (&src_sig[2*MANT_W:MANT_W]);
  end

  // S1 register; the lower L (L_uf) is the same bit as G, so it is stored once.
  logic              s1_l, s1_g, s1_s, s1_g_uf, s1_s_uf, s1_ones, s1_sign;
  logic [MANT_W-1:0] s1_frac;
  logic [2:0]        s1_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_l     <= 1'b0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_g_uf  <= 1'b0;
      s1_s_uf  <= 1'b0;
      s1_ones  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_frac  <= '0;
      s1_rm    <= '0;
    end else if (s1_adv) begin
      s1_valid <= src_valid;
      if (src_valid) begin
        s1_l    <= c_l;
        s1_g    <= c_g;
        s1_s    <= c_s;
        s1_g_uf <= c_g_uf;
        s1_s_uf <= c_s_uf;
        s1_ones <= c_ones;
        s1_sign <= src_sign;
        s1_frac <= c_frac;
        s1_rm   <= src_rm;
      end
    end
  end

  // S2 combinational: apply rounding and evaluate tininess after rounding.
  logic              inc, inc_uf, c_inexact, c_uf;
  logic [MANT_W:0]   rounded;

  always_comb begin
    inc       = inc_fn(s1_rm, s1_sign, s1_l, s1_g, s1_s);
    inc_uf    = inc_fn(s1_rm, s1_sign, s1_g, s1_g_uf, s1_s_uf);
    rounded   = {1'b0, s1_frac} + {{MANT_W{1'b0}}, inc};
    c_inexact = s1_g | s1_s;
    c_uf      = c_inexact & ~(s1_ones & inc_uf);
  end

  // S2 register drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      frac_o    <= '0;
      carry_o   <= 1'b0;
      inexact_o <= 1'b0;
      uf_o      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        frac_o    <= rounded[MANT_W-1:0];
        carry_o   <= rounded[MANT_W];
        inexact_o <= c_inexact;
        uf_o      <= c_uf;
      end
    end
  end

  assign out_valid_o = s2_valid;

`ifndef SYNTHESIS
  // A zero shift count is outside the legal range of this stage.
  rsh_nonzero_a: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid_i && in_ready_o) |-> (rsh_num_i != '0));
`endif

endmodule

// File: tb/tb_fmul_rsh_round_pipe.sv
// tb_fmul_rsh_round_pipe: directed table vectors plus sequences for backpressure,
// throughput and mid-operation reset on the F16 configuration.
module tb_fmul_rsh_round_pipe;
  localparam int MANT_W = 10;
  localparam int SIG_W  = 2 * (MANT_W + 1);
  localparam int RSH_W  = 4;
  localparam int RW     = MANT_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [SIG_W-1:0]  sig_mul_i = '0;
  logic [RSH_W-1:0]  rsh_num_i = 4'd1;
  logic [2:0]        rm_i = '0;
  logic              sign_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [MANT_W-1:0] frac_o;
  logic              carry_o, inexact_o, uf_o;

  fmul_rsh_round_pipe #(.MANT_W(MANT_W), .RSH_W(RSH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sig_mul_i(sig_mul_i), .rsh_num_i(rsh_num_i), .rm_i(rm_i), .sign_i(sign_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .frac_o(frac_o), .carry_o(carry_o), .inexact_o(inexact_o), .uf_o(uf_o)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct packed {
    logic [SIG_W-1:0]  sig;
    logic [RSH_W-1:0]  rsh;
    logic [2:0]        rm;
    logic              sign;
    logic [MANT_W-1:0] frac;
    logic              carry;
    logic              inexact;
    logic              uf;
  } vec_t;
  vec_t vecs[$];

  // Reference model written straight from the bit-position definitions.
  function automatic logic getb(input logic [SIG_W-1:0] sig, input int idx);
    if (idx < 0 || idx >= SIG_W) return 1'b0;
    return sig[idx];
  endfunction

  function automatic logic inc_m(input logic [2:0] rm, input logic sign,
                                 input logic l, input logic g, input logic s);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sign & (g | s);
      3'd3:    return !sign & (g | s);
      3'd4:    return g;
      default: return g & (l | s);
    endcase
  endfunction

  function automatic logic [RW-1:0] model(input logic [SIG_W-1:0] sig, input logic [RSH_W-1:0] rsh,
                                          input logic [2:0] rm, input logic sign);
    int p;
    logic l, g, s, luf, guf, suf, ones, inex, uf;
    logic [MANT_W-1:0] ft;
    logic [MANT_W:0] r;
    p = MANT_W + int'(rsh);
    l = getb(sig, p);
    g = getb(sig, p - 1);
    s = 1'b0;
    for (int i = 0; i <= p - 2; i++) s = s | getb(sig, i);
    luf = getb(sig, p - 1);
    guf = getb(sig, p - 2);
    suf = 1'b0;
    for (int i = 0; i <= p - 3; i++) suf = suf | getb(sig, i);
    for (int j = 0; j < MANT_W; j++) ft[j] = getb(sig, p + j);
    r = {1'b0, ft} + {{MANT_W{1'b0}}, inc_m(rm, sign, l, g, s)};
    ones = 1'b1;
    for (int j = MANT_W; j <= 2 * MANT_W; j++) ones = ones & sig[j];
    inex = g | s;
    uf = inex & ~((rsh == 4'd1) & ones & inc_m(rm, sign, luf, guf, suf));
    return {r, inex, uf};
  endfunction

  // Scoreboard: compares each output transfer and checks stability during stalls.
  logic [RW-1:0] held;
  logic held_valid = 1'b0;
  always @(negedge clk) begin
    logic [RW-1:0] act, e;
    if (!rst_n || !out_valid_o) begin
      held_valid = 1'b0;
    end else begin
      act = {carry_o, frac_o, inexact_o, uf_o};
      if (held_valid) begin
        checks++;
        if (act !== held) begin
          failures++;
          $display("FAIL stall_stable: got %h, held %h", act, held);
        end
      end
      if (out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got %h with empty queue", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL out_data: got {c,frac,ix,uf}=%h, expected %h", act, e);
          end
        end
        held_valid = 1'b0;
      end else begin
        held = act;
        held_valid = 1'b1;
      end
    end
  end

  // Driver: present one beat and hold it until accepted (bounded).
  task automatic send(input logic [SIG_W-1:0] sig, input logic [RSH_W-1:0] rsh,
                      input logic [2:0] rm, input logic sign, input logic [RW-1:0] exp);
    int waited;
    logic acc;
    sig_mul_i = sig; rsh_num_i = rsh; rm_i = rm; sign_i = sign;
    in_valid_i = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout: in_ready_o=%b after %0d cycles, required 1", in_ready_o, waited);
    end else begin
      exp_q.push_back(exp);
    end
  endtask

  task automatic wait_lat(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_o && n < 50);
  endtask

  task automatic check_lat(input string name, input int n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL %s: latency %0d, required 2", name, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || frac_o !== '0 ||
        carry_o !== 1'b0 || inexact_o !== 1'b0 || uf_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: ov=%b ir=%b frac=%h c=%b ix=%b uf=%b, required 0 1 000 0 0 0",
               name, out_valid_o, in_ready_o, frac_o, carry_o, inexact_o, uf_o);
    end
  endtask

  initial begin
    int n, t0;
    logic [SIG_W-1:0] rs;
    logic [RSH_W-1:0] rr;
    logic [2:0] rm;
    logic sg;

    //            sig        rsh   rm    sign  frac      c     ix    uf
    vecs.push_back({22'h1FFC00, 4'd1,  3'd0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1});
    vecs.push_back({22'h1FFE00, 4'd1,  3'd0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0});
    vecs.push_back({22'h100000, 4'd13, 3'd3, 1'b0, 10'h001, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h100000, 4'd13, 3'd2, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h100000, 4'd2,  3'd1, 1'b0, 10'h100, 1'b0, 1'b0, 1'b0});
    vecs.push_back({22'h1FFC00, 4'd1,  3'd1, 1'b0, 10'h3FF, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h1FFE00, 4'd1,  3'd4, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0});
    vecs.push_back({22'h100000, 4'd13, 3'd2, 1'b1, 10'h001, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h3FFFFF, 4'd15, 3'd4, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h180000, 4'd3,  3'd0, 1'b0, 10'h0C0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({22'h3FFFFF, 4'd4,  3'd0, 1'b0, 10'h100, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h000C00, 4'd2,  3'd7, 1'b0, 10'h001, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h1FFC00, 4'd1,  3'd3, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h1FFC01, 4'd1,  3'd3, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0});
    vecs.push_back({22'h000800, 4'd2,  3'd0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h000800, 4'd2,  3'd4, 1'b0, 10'h001, 1'b0, 1'b1, 1'b1});
    vecs.push_back({22'h0FFE00, 4'd1,  3'd0, 1'b0, 10'h200, 1'b0, 1'b1, 1'b1});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready_i = 1'b1;

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].sig, vecs[i].rsh, vecs[i].rm, vecs[i].sign,
           {vecs[i].carry, vecs[i].frac, vecs[i].inexact, vecs[i].uf});
      wait_lat(n);
      check_lat($sformatf("vec%0d_latency", i), n);
      @(posedge clk);
      #1;
    end
    wait_drain("vec_drain");

    // Full throughput: four back-to-back beats with the output always ready
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      rs = SIG_W'($urandom_range(0, 32'h3FFFFF));
      rr = RSH_W'($urandom_range(1, 15));
      rm = 3'($urandom_range(0, 7));
      sg = 1'($urandom_range(0, 1));
      send(rs, rr, rm, sg, model(rs, rr, rm, sg));
    end
    checks++;
    if (cyc - t0 != 4) begin
      failures++;
      $display("FAIL throughput: %0d cycles for 4 beats, required 4", cyc - t0);
    end
    wait_drain("throughput_drain");

    // Backpressure: 8 random beats with out_ready_i toggling 1,0,0,1,...
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rs = SIG_W'($urandom_range(0, 32'h3FFFFF));
          rr = RSH_W'($urandom_range(1, 15));
          rm = 3'($urandom_range(0, 7));
          sg = 1'($urandom_range(0, 1));
          send(rs, rr, rm, sg, model(rs, rr, rm, sg));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready_i = (k % 4 == 0) || (k % 4 == 3);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready_i = 1'b1;
    wait_drain("backpressure_drain");

    // Reset with two beats in flight
    out_ready_i = 1'b0;
    send(22'h1FFC00, 4'd1, 3'd0, 1'b0, 13'h0);
    send(22'h100000, 4'd13, 3'd3, 1'b0, 13'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset_inflight");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready_i = 1'b1;
    send(22'h100000, 4'd2, 3'd1, 1'b0, {1'b0, 10'h100, 1'b0, 1'b0});
    wait_lat(n);
    check_lat("post_reset_latency", n);
    wait_drain("post_reset_drain");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
